// File: rtl/data_sram_bridge_if.sv
// Sram-like data bus between the M-stage bridge (master) and the data cache / AXI bridge (slave).
// One request outstanding at a time: req/addr_ok accepts, data_ok completes.
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Turns the level-held M-stage access into a single sram-like transaction and
// holds the returned load data until M advances, so a stalled access is never reissued.
module data_sram_bridge (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m_req,
  input  logic                m_wr,
  input  logic [1:0]          m_size,
  input  logic [31:0]         m_addr,
  input  logic [31:0]         m_wdata,
  input  logic                m_stall,
  output logic                m_busy,
  output logic [31:0]         m_rdata,
  data_sram_bridge_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req) begin
            state <= bus.data_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (bus.data_addr_ok) begin
            state <= DATA;
          end
        end
        // An accepted access always drains, even if the pipeline flushes meanwhile.
        DATA: begin
          if (bus.data_data_ok) begin
            rdata_q <= bus.data_rdata;
            state   <= m_stall ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!m_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request is issued combinationally from IDLE so a ready slave gives one-cycle turnaround.
  assign bus.data_req   = ((state == IDLE) && m_req) || (state == ADDR);
  assign bus.data_wr    = m_wr;
  assign bus.data_size  = m_size;
  assign bus.data_addr  = m_addr;
  assign bus.data_wdata = m_wdata;

  assign m_busy  = ((state == IDLE) && m_req) || (state == ADDR) ||
                   ((state == DATA) && !bus.data_data_ok);
  assign m_rdata = ((state == DATA) && bus.data_data_ok) ? bus.data_rdata : rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed vector table, reset corner sequence,
// and a randomized run checked against a transaction-level reference model.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_req, m_wr, m_stall;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_busy;
  logic [31:0] m_rdata;

  data_sram_bridge_if bus ();

  data_sram_bridge dut (
    .clk     (clk),
    .resetn  (resetn),
    .m_req   (m_req),
    .m_wr    (m_wr),
    .m_size  (m_size),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_stall (m_stall),
    .m_busy  (m_busy),
    .m_rdata (m_rdata),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        exp_req;
    logic        exp_busy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic stall, input logic aok, input logic dok,
                              input logic [31:0] rd, input logic exp_req,
                              input logic exp_busy, input logic [31:0] exp_rdata);
    vec_t v;
    v.req = req; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.aok = aok; v.dok = dok; v.rd = rd;
    v.exp_req = exp_req; v.exp_busy = exp_busy; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic stall,
                       input logic aok, input logic dok, input logic [31:0] rd);
    m_req = req; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata; m_stall = stall;
    bus.data_addr_ok = aok; bus.data_data_ok = dok; bus.data_rdata = rd;
  endtask

  // Reference model state: access accepted by slave, completed-but-held, last returned data.
  bit          acc, held, active, issuing, old_acc, done_now;
  logic [31:0] last;
  logic [31:0] rnd_rd;
  logic        exp_req, exp_busy;
  logic [31:0] exp_rd;
  int          n_xfer;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    drive(0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0);

    // Reset state: IDLE, rdata_q cleared, req and busy follow m_req.
    @(posedge clk); #1;
    m_req = 1'b1;
    #3;
    check("reset_req_follows", {127'd0, bus.data_req}, 128'd1);
    check("reset_busy_follows", {127'd0, m_busy}, 128'd1);
    check("reset_rdata", {96'd0, m_rdata}, 128'd0);
    @(posedge clk); #1;
    m_req = 1'b0;
    #3;
    check("reset_req_idle", {126'd0, bus.data_req, m_busy}, 128'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single-cycle load, spurious data_ok in IDLE
    vecs.push_back(mk(1,0,2,32'h8000_0010,0,0,1,0,0,                 1,1,32'h0));
    vecs.push_back(mk(1,0,2,32'h8000_0010,0,0,0,1,32'hDEAD_BEEF,     0,0,32'hDEAD_BEEF));
    vecs.push_back(mk(0,0,2,32'h8000_0010,0,0,0,1,32'h7777_7777,     0,0,32'hDEAD_BEEF));
    // Delayed handshake: 3 cycles without addr_ok (one spurious data_ok in ADDR)
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,0,0,0,                 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,0,1,32'h9999_9999,     1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,0,0,0,                 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,1,0,0,                 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,0,0,0,                 0,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,2,32'h8000_0020,0,0,0,1,32'hCAFE_F00D,     0,0,32'hCAFE_F00D));
    vecs.push_back(mk(0,0,2,32'h0,0,0,0,0,0,                         0,0,32'hCAFE_F00D));
    // Completion under external stall, then held in DONE
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,1,0,0,                 1,1,32'hCAFE_F00D));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,0,1,32'h1234_5678,     0,0,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,1,1,32'hFFFF_FFFF,     0,0,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,0,0,0,                 0,0,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,0,1,32'hFFFF_FFFF,     0,0,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,1,0,0,0,                 0,0,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0030,0,0,0,0,0,                 0,0,32'h1234_5678));
    // After DONE->IDLE the next request issues
    vecs.push_back(mk(1,0,2,32'h8000_0040,0,0,0,0,0,                 1,1,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0040,0,0,1,0,0,                 1,1,32'h1234_5678));
    vecs.push_back(mk(1,0,2,32'h8000_0040,0,0,0,1,32'h0BAD_F00D,     0,0,32'h0BAD_F00D));
    // Store byte
    vecs.push_back(mk(1,1,0,32'hBFAF_0003,32'hAB,0,0,0,0,            1,1,32'h0BAD_F00D));
    vecs.push_back(mk(1,1,0,32'hBFAF_0003,32'hAB,0,1,0,0,            1,1,32'h0BAD_F00D));
    vecs.push_back(mk(1,1,0,32'hBFAF_0003,32'hAB,0,0,1,32'h55AA_55AA,0,0,32'h55AA_55AA));
    // Back-to-back loads, no bubble
    vecs.push_back(mk(1,0,2,32'h8000_0100,0,0,1,0,0,                 1,1,32'h55AA_55AA));
    vecs.push_back(mk(1,0,2,32'h8000_0100,0,0,0,1,32'h1111_1111,     0,0,32'h1111_1111));
    vecs.push_back(mk(1,0,1,32'h8000_0104,0,0,1,0,0,                 1,1,32'h1111_1111));
    vecs.push_back(mk(1,0,1,32'h8000_0104,0,0,0,1,32'h2222_2222,     0,0,32'h2222_2222));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0,0,0,                         0,0,32'h2222_2222));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
            vecs[i].stall, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      #3;
      $display("vec %0d: req=%b busy=%b rdata=%h", i, bus.data_req, m_busy, m_rdata);
      check($sformatf("vec%0d_req", i), {127'd0, bus.data_req}, {127'd0, vecs[i].exp_req});
      check($sformatf("vec%0d_busy", i), {127'd0, m_busy}, {127'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_rdata", i), {96'd0, m_rdata}, {96'd0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_passthru", i),
            {61'd0, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata},
            {61'd0, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata});
      @(posedge clk); #1;
    end

    // Reset while in DATA abandons the access; a late data_ok is ignored.
    drive(1, 0, 2'd2, 32'h8000_0200, 32'd0, 0, 1, 0, 32'd0);
    #3;
    check("rst_mid_issue", {127'd0, bus.data_req}, 128'd1);
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    resetn = 1'b0;
    #3;
    check("rst_mid_data_busy", {126'd0, bus.data_req, m_busy}, 128'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(0, 0, 2'd2, 32'h8000_0200, 32'd0, 0, 0, 1, 32'hEEEE_EEEE);
    #3;
    $display("reset-mid-access: req=%b busy=%b rdata=%h", bus.data_req, m_busy, m_rdata);
    check("rst_mid_idle", {126'd0, bus.data_req, m_busy}, 128'd0);
    check("rst_mid_rdata", {96'd0, m_rdata}, 128'd0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    #3;
    check("rst_late_dok_rdata", {96'd0, m_rdata}, 128'd0);
    m_req = 1'b1;
    #1;
    check("rst_after_issue", {126'd0, bus.data_req, m_busy}, 128'd3);
    @(posedge clk); #1;

    // Randomized run against the transaction-level model.
    resetn = 1'b0;
    drive(0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    acc = 0; held = 0; active = 0; last = 32'd0; n_xfer = 0;

    for (int c = 0; c < 800; c++) begin
      if (!(held || active)) begin
        m_req = ($urandom_range(0, 9) < 6);
        if (m_req) begin
          active  = 1;
          m_wr    = $urandom_range(0, 1);
          m_size  = 2'($urandom_range(0, 2));
          m_addr  = $urandom;
          m_wdata = $urandom;
        end
      end
      m_stall = ($urandom_range(0, 9) < 5);
      issuing = m_req && !acc && !held;
      bus.data_addr_ok = issuing && ($urandom_range(0, 2) == 0);
      if (acc) bus.data_data_ok = ($urandom_range(0, 2) == 0);
      else     bus.data_data_ok = !bus.data_addr_ok && ($urandom_range(0, 4) == 0);
      rnd_rd = $urandom;
      bus.data_rdata = rnd_rd;
      #3;
      exp_req  = issuing;
      exp_busy = issuing || (acc && !bus.data_data_ok);
      exp_rd   = (acc && bus.data_data_ok) ? rnd_rd : last;
      check($sformatf("rnd%0d_req", c), {127'd0, bus.data_req}, {127'd0, exp_req});
      check($sformatf("rnd%0d_busy", c), {127'd0, m_busy}, {127'd0, exp_busy});
      check($sformatf("rnd%0d_rdata", c), {96'd0, m_rdata}, {96'd0, exp_rd});
      check($sformatf("rnd%0d_addr", c), {96'd0, bus.data_addr}, {96'd0, m_addr});

      old_acc  = acc;
      done_now = old_acc && bus.data_data_ok;
      if (issuing && bus.data_addr_ok) acc = 1;
      if (done_now) begin
        acc    = 0;
        last   = rnd_rd;
        held   = m_stall;
        active = 0;
        n_xfer++;
        $display("xfer %0d: wr=%b addr=%h rdata=%h stall=%b", n_xfer, m_wr, m_addr, rnd_rd, m_stall);
      end else if (held && !m_stall) begin
        held = 0;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
